// File: rtl/decode_ctrl_stage.sv
// ID stage for the 5-stage MIPS pipeline. Decodes the IF/ID word, registers controls into ID/EX,
// detects load-use hazards and counts stall cycles (saturating).
module decode_ctrl_stage #(
    parameter int ALU_OP_W   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic                  ex_RegWrite_o,
    output logic [ALU_OP_W-1:0]   ex_ALU_op_o,
    output logic                  ex_ALUSrc_o,
    output logic                  ex_RegDst_o,
    output logic                  ex_Branch_o,
    output logic                  ex_BranchNe_o,
    output logic                  ex_Jump_o,
    output logic                  ex_MemRead_o,
    output logic                  ex_MemtoReg_o,
    output logic                  ex_MemWrite_o,
    output logic [REG_ADDR_W-1:0] ex_rs_o,
    output logic [REG_ADDR_W-1:0] ex_rt_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  illegal_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs, rt, rd, dest;
    logic [2:0]            aluOp3;
    logic [ALU_OP_W-1:0]   aluOp;
    logic regWrite, aluSrc, regDst, branch, branchNe, jump;
    logic memRead, memtoReg, memWrite, illegalOp, usesRs, usesRt;
    logic take;
    logic unusedBits;

    assign opcode     = instr_i[31:26];
    assign rs         = instr_i[21 +: REG_ADDR_W];
    assign rt         = instr_i[16 +: REG_ADDR_W];
    assign rd         = instr_i[11 +: REG_ADDR_W];
    assign unusedBits = ^instr_i[10:0];

    always_comb begin
        regWrite  = 1'b0;
        aluOp3    = 3'b000;
        aluSrc    = 1'b0;
        regDst    = 1'b0;
        branch    = 1'b0;
        branchNe  = 1'b0;
        jump      = 1'b0;
        memRead   = 1'b0;
        memtoReg  = 1'b0;
        memWrite  = 1'b0;
        illegalOp = 1'b0;
        usesRs    = 1'b1;
        usesRt    = 1'b0;
        case (opcode)
            OP_RTYPE: begin regWrite = 1'b1; regDst = 1'b1; aluOp3 = 3'b010; usesRt = 1'b1; end
            OP_LW:    begin aluSrc = 1'b1; memRead = 1'b1; memtoReg = 1'b1; regWrite = 1'b1; end
            OP_SW:    begin aluSrc = 1'b1; memWrite = 1'b1; usesRt = 1'b1; end
            OP_BEQ:   begin aluOp3 = 3'b001; branch = 1'b1; usesRt = 1'b1; end
            OP_BNE:   begin aluOp3 = 3'b001; branchNe = 1'b1; usesRt = 1'b1; end
            OP_ADDI:  begin aluSrc = 1'b1; regWrite = 1'b1; end
            OP_SLTI:  begin aluOp3 = 3'b011; aluSrc = 1'b1; regWrite = 1'b1; end
            OP_ORI:   begin aluOp3 = 3'b100; aluSrc = 1'b1; regWrite = 1'b1; end
            OP_J:     begin jump = 1'b1; usesRs = 1'b0; end
            default:  illegalOp = 1'b1;
        endcase
        // $0 is hardwired, so a write to it is dropped here; the all-zero word becomes a NOP.
        dest = regDst ? rd : rt;
        if (dest == '0) regWrite = 1'b0;
        aluOp      = '0;
        aluOp[2:0] = aluOp3;
    end

    // Handshake: stall_o=1 means upstream must hold PC and IF/ID this cycle; ID/EX takes a bubble.
    // An instruction moves into ID/EX only when instr_valid_i=1, flush_i=0 and stall_o=0.
    assign stall_o = ex_valid_o & ex_MemRead_o & (ex_rt_o != '0) & instr_valid_i & ~flush_i &
                     ((usesRs & (rs == ex_rt_o)) | (usesRt & (rt == ex_rt_o)));
    assign take    = instr_valid_i & ~flush_i & ~stall_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_RegWrite_o <= 1'b0;
            ex_ALU_op_o   <= '0;
            ex_ALUSrc_o   <= 1'b0;
            ex_RegDst_o   <= 1'b0;
            ex_Branch_o   <= 1'b0;
            ex_BranchNe_o <= 1'b0;
            ex_Jump_o     <= 1'b0;
            ex_MemRead_o  <= 1'b0;
            ex_MemtoReg_o <= 1'b0;
            ex_MemWrite_o <= 1'b0;
            ex_rs_o       <= '0;
            ex_rt_o       <= '0;
            ex_rd_o       <= '0;
            illegal_o     <= 1'b0;
            stall_cnt_o   <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            // Bubble (everything zero) unless a live instruction is admitted.
            ex_valid_o    <= take;
            ex_RegWrite_o <= take & regWrite;
            ex_ALU_op_o   <= take ? aluOp : '0;
            ex_ALUSrc_o   <= take & aluSrc;
            ex_RegDst_o   <= take & regDst;
            ex_Branch_o   <= take & branch;
            ex_BranchNe_o <= take & branchNe;
            ex_Jump_o     <= take & jump;
            ex_MemRead_o  <= take & memRead;
            ex_MemtoReg_o <= take & memtoReg;
            ex_MemWrite_o <= take & memWrite;
            ex_rs_o       <= take ? rs : '0;
            ex_rt_o       <= take ? rt : '0;
            ex_rd_o       <= take ? rd : '0;
            illegal_o     <= take & illegalOp;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: decode sweep, $0 suppression, load-use stalls,
// flush priority, reset mid-stall and counter saturation (second instance with CNT_W=2).
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid;
    logic        flush;

    logic        stall, ex_valid, ex_rw, ex_src, ex_dst, ex_br, ex_bne, ex_j, ex_mr, ex_m2r, ex_mw, ill;
    logic [2:0]  ex_alu;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] cnt;

    logic        s_stall, s_valid, s_rw, s_src, s_dst, s_br, s_bne, s_j, s_mr, s_m2r, s_mw, s_ill;
    logic [2:0]  s_alu;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {valid, RegWrite, ALU_op, ALUSrc, RegDst, Branch, BranchNe, Jump, MemRead, MemtoReg, MemWrite, illegal}
    wire [13:0] ctrl = {ex_valid, ex_rw, ex_alu, ex_src, ex_dst, ex_br, ex_bne, ex_j, ex_mr, ex_m2r, ex_mw, ill};

    localparam logic [31:0] LW_T0  = 32'h8E08_0000;  // lw   $t0,0($s0)
    localparam logic [31:0] ADD_T1 = 32'h010A_4820;  // add  $t1,$t0,$t2
    localparam logic [31:0] SW_T0  = 32'hAE28_0000;  // sw   $t0,0($s1)
    localparam logic [31:0] ADDI_N = 32'h2169_0001;  // addi $t1,$t3,1
    localparam logic [31:0] LW_T1  = 32'h8D09_0000;  // lw   $t1,0($t0)
    localparam logic [31:0] ADD_T2 = 32'h0120_5020;  // add  $t2,$t1,$0
    localparam logic [13:0] C_ADD  = 14'b1_1_010_0_1_0_0_0_0_0_0_0;
    localparam logic [13:0] C_LW   = 14'b1_1_000_1_0_0_0_0_1_1_0_0;
    localparam logic [13:0] C_SW   = 14'b1_0_000_1_0_0_0_0_0_0_1_0;

    always #5 clk = ~clk;

    decode_ctrl_stage dut (
        .clk_i(clk), .rst_i(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
        .stall_o(stall), .ex_valid_o(ex_valid), .ex_RegWrite_o(ex_rw), .ex_ALU_op_o(ex_alu),
        .ex_ALUSrc_o(ex_src), .ex_RegDst_o(ex_dst), .ex_Branch_o(ex_br), .ex_BranchNe_o(ex_bne),
        .ex_Jump_o(ex_j), .ex_MemRead_o(ex_mr), .ex_MemtoReg_o(ex_m2r), .ex_MemWrite_o(ex_mw),
        .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd), .illegal_o(ill), .stall_cnt_o(cnt)
    );

    decode_ctrl_stage #(.CNT_W(2)) sat_dut (
        .clk_i(clk), .rst_i(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
        .stall_o(s_stall), .ex_valid_o(s_valid), .ex_RegWrite_o(s_rw), .ex_ALU_op_o(s_alu),
        .ex_ALUSrc_o(s_src), .ex_RegDst_o(s_dst), .ex_Branch_o(s_br), .ex_BranchNe_o(s_bne),
        .ex_Jump_o(s_j), .ex_MemRead_o(s_mr), .ex_MemtoReg_o(s_m2r), .ex_MemWrite_o(s_mw),
        .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd), .illegal_o(s_ill), .stall_cnt_o(s_cnt)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task drive(input logic [31:0] i, input logic v, input logic f);
        instr = i;
        valid = v;
        flush = f;
        #1;
    endtask

    task test_reset;
        rst_n = 1'b0;
        drive(LW_T0, 1'b1, 1'b0);
        tick;
        tick;
        if (ctrl !== 14'd0) begin $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 14'd0); n_err++; end
        n_cmp++;
        if ({ex_rs, ex_rt, ex_rd} !== 15'd0) begin $display("FAIL reset_regs got=%h exp=0", {ex_rs, ex_rt, ex_rd}); n_err++; end
        n_cmp++;
        if (cnt !== 16'd0) begin $display("FAIL reset_cnt got=%0d exp=0", cnt); n_err++; end
        n_cmp++;
        if (stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", stall); n_err++; end
        n_cmp++;
        rst_n = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        tick;
    endtask

    task test_decode_sweep;
        logic [31:0] vi [12];
        logic [13:0] vc [12];
        logic [4:0]  vr [12];
        vi = '{ADD_T1, LW_T0, SW_T0, 32'h1022_0004, 32'h1422_0004, 32'h2128_0005,
               32'h2823_0007, 32'h3424_00FF, 32'h0800_0010, 32'hFC00_0000, 32'h0022_0020, 32'h0};
        vc = '{C_ADD, C_LW, C_SW,
               14'b1_0_001_0_0_1_0_0_0_0_0_0,   // beq
               14'b1_0_001_0_0_0_1_0_0_0_0_0,   // bne
               14'b1_1_000_1_0_0_0_0_0_0_0_0,   // addi
               14'b1_1_011_1_0_0_0_0_0_0_0_0,   // slti
               14'b1_1_100_1_0_0_0_0_0_0_0_0,   // ori
               14'b1_0_000_0_0_0_0_1_0_0_0_0,   // j
               14'b1_0_000_0_0_0_0_0_0_0_0_1,   // opcode 0x3F
               14'b1_0_010_0_1_0_0_0_0_0_0_0,   // add $0 -> no write
               14'b1_0_010_0_1_0_0_0_0_0_0_0};  // all-zero NOP
        vr = '{5'd10, 5'd8, 5'd8, 5'd2, 5'd2, 5'd8, 5'd3, 5'd4, 5'd0, 5'd0, 5'd2, 5'd0};
        for (int i = 0; i < 12; i++) begin
            drive(vi[i], 1'b1, 1'b0);
            tick;
            if (ctrl !== vc[i]) begin $display("FAIL dec_ctrl[%0d] got=%b exp=%b", i, ctrl, vc[i]); n_err++; end
            n_cmp++;
            if (ex_rt !== vr[i]) begin $display("FAIL dec_rt[%0d] got=%0d exp=%0d", i, ex_rt, vr[i]); n_err++; end
            n_cmp++;
            drive(32'h0, 1'b0, 1'b0);
            tick;
            if (ctrl !== 14'd0) begin $display("FAIL dec_bubble[%0d] got=%b exp=0", i, ctrl); n_err++; end
            n_cmp++;
        end
    endtask

    task test_load_use;
        logic [31:0] use_i [3];
        logic        exp_st [3];
        logic [13:0] exp_c [3];
        logic [15:0] exp_cnt [3];
        use_i   = '{ADD_T1, SW_T0, ADDI_N};
        exp_st  = '{1'b1, 1'b1, 1'b0};
        exp_c   = '{C_ADD, C_SW, 14'b1_1_000_1_0_0_0_0_0_0_0_0};
        exp_cnt = '{16'd1, 16'd2, 16'd2};
        for (int k = 0; k < 3; k++) begin
            drive(LW_T0, 1'b1, 1'b0);
            tick;
            drive(use_i[k], 1'b1, 1'b0);
            if (stall !== exp_st[k]) begin $display("FAIL lu_stall[%0d] got=%b exp=%b", k, stall, exp_st[k]); n_err++; end
            n_cmp++;
            if (exp_st[k]) begin
                tick;
                if (ctrl !== 14'd0) begin $display("FAIL lu_bubble[%0d] got=%b exp=0", k, ctrl); n_err++; end
                n_cmp++;
                if (stall !== 1'b0) begin $display("FAIL lu_one_cycle[%0d] got=%b exp=0", k, stall); n_err++; end
                n_cmp++;
            end
            tick;
            if (ctrl !== exp_c[k]) begin $display("FAIL lu_use[%0d] got=%b exp=%b", k, ctrl, exp_c[k]); n_err++; end
            n_cmp++;
            if (cnt !== exp_cnt[k]) begin $display("FAIL lu_cnt[%0d] got=%0d exp=%0d", k, cnt, exp_cnt[k]); n_err++; end
            n_cmp++;
            drive(32'h0, 1'b0, 1'b0);
            tick;
        end
        drive(LW_T0, 1'b1, 1'b0);
        tick;
        drive(ADD_T1, 1'b1, 1'b0);
        tick;
        tick;
        if ({ex_rs, ex_rt, ex_rd} !== {5'd8, 5'd10, 5'd9}) begin
            $display("FAIL lu_specs got=%0d/%0d/%0d exp=8/10/9", ex_rs, ex_rt, ex_rd); n_err++;
        end
        n_cmp++;
        drive(32'h0, 1'b0, 1'b0);
        tick;
    endtask

    task test_flush;
        drive(LW_T0, 1'b1, 1'b0);
        tick;
        drive(ADD_T1, 1'b1, 1'b1);
        if (stall !== 1'b0) begin $display("FAIL fl_stall got=%b exp=0", stall); n_err++; end
        n_cmp++;
        tick;
        if (ctrl !== 14'd0) begin $display("FAIL fl_bubble got=%b exp=0", ctrl); n_err++; end
        n_cmp++;
        if (cnt !== 16'd3) begin $display("FAIL fl_cnt got=%0d exp=3", cnt); n_err++; end
        n_cmp++;
        drive(32'h0, 1'b0, 1'b0);
        tick;
    endtask

    task test_back_to_back;
        drive(LW_T0, 1'b1, 1'b0);
        tick;
        drive(LW_T1, 1'b1, 1'b0);
        if (stall !== 1'b1) begin $display("FAIL b2b_stall1 got=%b exp=1", stall); n_err++; end
        n_cmp++;
        tick;
        tick;
        if (ctrl !== C_LW || ex_rt !== 5'd9) begin $display("FAIL b2b_lw2 got=%b rt=%0d exp=%b rt=9", ctrl, ex_rt, C_LW); n_err++; end
        n_cmp++;
        drive(ADD_T2, 1'b1, 1'b0);
        if (stall !== 1'b1) begin $display("FAIL b2b_stall2 got=%b exp=1", stall); n_err++; end
        n_cmp++;
        tick;
        tick;
        if (ex_valid !== 1'b1 || ex_rs !== 5'd9) begin $display("FAIL b2b_add got=%b rs=%0d exp=1 rs=9", ex_valid, ex_rs); n_err++; end
        n_cmp++;
        if (cnt !== 16'd5) begin $display("FAIL b2b_cnt got=%0d exp=5", cnt); n_err++; end
        n_cmp++;
        drive(32'h0, 1'b0, 1'b0);
        tick;
    endtask

    task test_reset_mid_stall;
        drive(LW_T0, 1'b1, 1'b0);
        tick;
        drive(ADD_T1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick;
        if (ctrl !== 14'd0 || cnt !== 16'd0) begin $display("FAIL rst_mid got=%b cnt=%0d exp=0 cnt=0", ctrl, cnt); n_err++; end
        n_cmp++;
        if (stall !== 1'b0) begin $display("FAIL rst_mid_stall got=%b exp=0", stall); n_err++; end
        n_cmp++;
        rst_n = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        tick;
    endtask

    task test_saturation;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(LW_T0, 1'b1, 1'b0);
            tick;
            drive(ADD_T1, 1'b1, 1'b0);
            tick;
            tick;
            if (s_cnt !== ((k > 3) ? 2'd3 : 2'(k))) begin $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, s_cnt, (k > 3) ? 3 : k); n_err++; end
            n_cmp++;
            if (cnt !== 16'(k)) begin $display("FAIL sat_wide_cnt[%0d] got=%0d exp=%0d", k, cnt, k); n_err++; end
            n_cmp++;
        end
        drive(32'h0, 1'b0, 1'b0);
        tick;
    endtask

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        valid = 1'b0;
        flush = 1'b0;
        test_reset;
        test_decode_sweep;
        test_load_use;
        test_flush;
        test_back_to_back;
        test_reset_mid_stall;
        test_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
